// File: rtl/led_pwm_driver.sv
// Multi-channel LED PWM driver: duty writes land in shadow registers and are
// committed together at each PWM period boundary. Optional gamma curve: LED_PWM_GAMMA_EN.
module led_pwm_driver #(
  parameter int CHANNELS = 8,
  parameter int DUTY_W   = 8,
  parameter int PRESCALE = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        duty_valid,
  output logic                        duty_ready,
  input  logic [$clog2(CHANNELS)-1:0] duty_ch,
  input  logic [DUTY_W-1:0]           duty_data,
  output logic                        frame_start,
  output logic [CHANNELS-1:0]         led
);
  localparam int CH_W  = $clog2(CHANNELS);
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic              ready_q;
  logic              frame_q;
  logic              tick;
  logic              commit;
  logic              wr_en;

  assign tick   = (pre_q == PRE_W'(PRESCALE - 1));
  assign commit = tick && (cnt_q == {DUTY_W{1'b1}});
  assign wr_en  = duty_valid && ready_q;

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      ready_q <= 1'b1;
      frame_q <= commit;
    end
  end

  assign duty_ready  = ready_q;
  assign frame_start = frame_q;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [DUTY_W-1:0] shadow_q;
      logic [DUTY_W-1:0] active_q;
      logic [DUTY_W-1:0] mapped;
      logic              led_q;
      logic              hit;

      // Out-of-range channel indices simply match no channel.
      assign hit = wr_en && (duty_ch == CH_W'(gi));

`ifdef LED_PWM_GAMMA_EN
      logic [2*DUTY_W-1:0] prod;
      assign prod   = {{DUTY_W{1'b0}}, shadow_q} * ({{DUTY_W{1'b0}}, shadow_q} + 1'b1);
      assign mapped = prod[2*DUTY_W-1:DUTY_W];
`else
      assign mapped = shadow_q;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_q <= '0;
          active_q <= '0;
          led_q    <= 1'b0;
        end else begin
          if (hit) begin
            shadow_q <= duty_data;
          end
          if (commit) begin
            active_q <= mapped;
          end
          led_q <= (cnt_q < active_q);
        end
      end

      assign led[gi] = led_q;
    end
  endgenerate

endmodule

// File: tb/tb_led_pwm_driver.sv
// Randomized self-checking bench for led_pwm_driver: two instances (8ch/8b/prescale 2
// and 6ch/4b/prescale 1) checked every cycle against a period-arithmetic reference model.
module tb_led_pwm_driver;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       va, vb;
  logic [2:0] cha, chb;
  logic [7:0] da;
  logic [3:0] db;
  logic       ra, rb, fsa, fsb;
  logic [7:0] leda;
  logic [5:0] ledb;

  always #5 clk = ~clk;

  led_pwm_driver #(.CHANNELS(8), .DUTY_W(8), .PRESCALE(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .duty_valid(va), .duty_ready(ra), .duty_ch(cha),
    .duty_data(da), .frame_start(fsa), .led(leda)
  );

  led_pwm_driver #(.CHANNELS(6), .DUTY_W(4), .PRESCALE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .duty_valid(vb), .duty_ready(rb), .duty_ch(chb),
    .duty_data(db), .frame_start(fsb), .led(ledb)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: time is the edge count n since reset release; the PWM counter
  // and commit instants follow directly from n by division.
  int P [2] = '{2, 1};
  int W [2] = '{8, 4};
  int C [2] = '{8, 6};
  int n;
  int shadow_m [2][8];
  int active_m [2][8];
  logic [7:0] led_m [2];
  bit fs_m [2];
  int acc0, acc1, acc2, acc7, acc_oth;
  int last0, last1, last2, last7, last_oth;

  function automatic int mapf(int d, int w);
`ifdef LED_PWM_GAMMA_EN
    return (d * (d + 1)) >> w;
`else
    return d;
`endif
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        shadow_m[k][i] = 0;
        active_m[k][i] = 0;
      end
      led_m[k] = '0;
      fs_m[k]  = 1'b0;
    end
    acc0 = 0; acc1 = 0; acc2 = 0; acc7 = 0; acc_oth = 0;
    last0 = 0; last1 = 0; last2 = 0; last7 = 0; last_oth = 0;
  endtask

  // Called at a negedge: drive inputs, take one rising edge, update model, compare.
  task automatic step(input bit wva, input int wcha, input int wda,
                      input bit wvb, input int wchb, input int wdb);
    int vv [2];
    int cc [2];
    int dd [2];
    vv = '{int'(wva), int'(wvb)};
    cc = '{wcha, wchb};
    dd = '{wda, wdb};
    va = wva; cha = 3'(wcha); da = 8'(wda);
    vb = wvb; chb = 3'(wchb); db = 4'(wdb);
    @(posedge clk);
    n++;
    for (int k = 0; k < 2; k++) begin
      int per, cprev;
      per   = P[k] << W[k];
      cprev = ((n - 1) / P[k]) % (1 << W[k]);
      for (int i = 0; i < 8; i++)
        led_m[k][i] = (i < C[k]) && (cprev < active_m[k][i]);
      fs_m[k] = (n % per == 0);
      if (fs_m[k])
        for (int i = 0; i < C[k]; i++) active_m[k][i] = mapf(shadow_m[k][i], W[k]);
      if (vv[k] != 0 && n >= 2 && cc[k] < C[k]) shadow_m[k][cc[k]] = dd[k];
    end
    @(negedge clk);
    check("led_a", int'(leda), int'(led_m[0]));
    check("frame_a", int'(fsa), int'(fs_m[0]));
    check("ready_a", int'(ra), int'(n >= 1));
    check("led_b", int'(ledb), int'(led_m[1][5:0]));
    check("frame_b", int'(fsb), int'(fs_m[1]));
    check("ready_b", int'(rb), int'(n >= 1));
    acc0 += int'(leda[0]);
    acc1 += int'(leda[1]);
    acc2 += int'(leda[2]);
    acc7 += int'(leda[7]);
    acc_oth += int'(leda[6:1] != 6'd0);
    if (n % 512 == 0) begin
      last0 = acc0; last1 = acc1; last2 = acc2; last7 = acc7; last_oth = acc_oth;
      acc0 = 0; acc1 = 0; acc2 = 0; acc7 = 0; acc_oth = 0;
    end
  endtask

  task automatic run_to(input int target);
    while (n < target) step(1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    va = 1'b0; vb = 1'b0; cha = '0; chb = '0; da = '0; db = '0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    check("rst_led_a", int'(leda), 0);
    check("rst_ready_a", int'(ra), 0);
    check("rst_led_b", int'(ledb), 0);
  endtask

  initial begin
    do_reset();

    // Basic duty: ch0=64, ch7=255 before the first commit at edge 512.
    run_to(9);
    step(1'b1, 0, 64, 1'b0, 0, 0);
    step(1'b1, 7, 255, 1'b0, 0, 0);
    run_to(511);
    check("pre_commit_led_a", int'(leda), 0);
    run_to(1024);
    check("cnt_ch0_p1", last0, mapf(64, 8) * 2);
    check("cnt_ch7_p1", last7, mapf(255, 8) * 2);
    check("cnt_other_p1", last_oth, 0);

    // Glitch-free update mid-period.
    run_to(1280);
    step(1'b1, 0, 200, 1'b0, 0, 0);
    run_to(1536);
    check("cnt_ch0_old", last0, mapf(64, 8) * 2);
    run_to(2048);
    check("cnt_ch0_new", last0, mapf(200, 8) * 2);

    // ch2=0, then a ch1 write sampled on the commit edge itself.
    step(1'b1, 2, 0, 1'b0, 0, 0);
    run_to(2559);
    step(1'b1, 1, 10, 1'b0, 0, 0);
    run_to(3072);
    check("cnt_ch1_collide", last1, 0);
    run_to(3584);
    check("cnt_ch1_next", last1, mapf(10, 8) * 2);
    check("cnt_ch2_zero", last2, 0);

    // Random writes to both instances, including out-of-range channels on B.
    repeat (1500) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
    end

    // Asynchronous reset mid-period: outputs clear before the next clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("async_led_a", int'(leda), 0);
    check("async_frame_a", int'(fsa), 0);
    check("async_ready_a", int'(ra), 0);
    check("async_led_b", int'(ledb), 0);
    check("async_ready_b", int'(rb), 0);
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // Instance B: out-of-range channels must leave all outputs alone.
    run_to(2);
    step(1'b0, 0, 0, 1'b1, 0, 5);
    step(1'b0, 0, 0, 1'b1, 7, 9);
    step(1'b0, 0, 0, 1'b1, 6, 3);
    step(1'b0, 0, 0, 1'b1, 5, 15);
    step(1'b0, 0, 0, 1'b1, 2, 0);
    run_to(100);
    repeat (300) begin
      step(1'b0, 0, 0, 1'b1, int'($urandom_range(6, 7)), int'($urandom_range(0, 15)));
    end
    run_to(520);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/led_pwm_driver.md
Name: led_pwm_driver

Overview:
- Downstream stage between the design's 8-bit LED value source (e.g. counter slice) and the output-only LED IOBs.
- Converts per-channel duty values into PWM waveforms for brightness control instead of raw on/off.
- Duty values are written over a valid/ready port into shadow registers.
- Shadows commit to the active registers only at a PWM period boundary, so a period never mixes old and new duty (glitch-free).

Parameters:
- CHANNELS, 8, number of LED outputs (≥2).
- DUTY_W, 8, duty/PWM counter width; period = 2^DUTY_W ticks.
- PRESCALE, 16, clk cycles per PWM tick (≥1).

Ports:
- clk  input  1  single design clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- duty_valid  input  1  write request.
- duty_ready  output  1  driver can accept a write.
- duty_ch  input  $clog2(CHANNELS)  target channel of the write.
- duty_data  input  DUTY_W  duty value for the target channel.
- frame_start  output  1  one-cycle pulse when a new PWM period begins with freshly committed duties.
- led  output  CHANNELS  PWM outputs to the LED IOBs; 1 = on.

Behaviour:
- Reset (rst_n low, asynchronous): all of the following clear immediately and stay 0 while rst_n is low:
  - prescaler pre, PWM counter cnt, every shadow[i], every active[i];
  - outputs led, frame_start, duty_ready.
- duty_ready: register; rises on the first clk edge after rst_n deasserts, then stays 1.
- Write acceptance: a write is accepted on a cycle with duty_valid & duty_ready.
  - shadow[duty_ch] <= duty_data.
  - duty_ch ≥ CHANNELS: write accepted, no register changes.
  - A writer may write every cycle; a later write to the same channel overwrites the earlier one.
- Prescaler and tick:
  - tick = (pre == PRESCALE-1).
  - On tick, pre <= 0; otherwise pre <= pre+1.
  - PRESCALE = 1: tick is high every cycle.
- PWM counter: on tick, cnt <= cnt+1, wrapping from 2^DUTY_W-1 to 0.
- Commit:
  - commit = tick & (cnt == 2^DUTY_W-1).
  - On commit: active[i] <= map(shadow[i]) for every i, and frame_start <= 1.
  - frame_start is 0 on all other cycles.
  - Because of this, frame_start is high during the first cycle in which cnt == 0.
- Write coinciding with commit: the commit uses the shadow value present before that edge. The new write lands in the next period.
- Output: every cycle, led[i] <= (cnt < active[i]). This is registered, so led lags the counter/active state by 1 cycle.
  - active = 0 gives a constant-off output.
  - active = 2^DUTY_W-1 gives on for (2^DUTY_W-1) of 2^DUTY_W ticks.
- First commit after reset occurs on clk edge number 2^DUTY_W × PRESCALE after release. Before it, all leds are 0.
- Reset mid-period: the period is abandoned. Counters and duties restart from 0; no frame_start pulse.
- map(d) = d when the optional feature is compiled out.

Optional Feature:
- Macro: LED_PWM_GAMMA_EN.
- Defined: at commit, map(d) = (d × (d+1)) >> DUTY_W, computed at 2×DUTY_W bits, giving a perceptual (≈square-law) curve.
  - DUTY_W = 8 examples: 0→0, 1→0, 16→1, 128→64, 255→255.
- Not defined: map(d) = d, and no multiplier is synthesised.

Test Plan:
- Reset/idle (CHANNELS=8, DUTY_W=8, PRESCALE=2): hold rst_n low 5 cycles, release → led=0, frame_start=0, duty_ready=1 from the first edge after release. led stays 0 until edge 512; frame_start pulses exactly at edge 512.
- Basic duty: write ch0=64, ch7=255 before the first commit → in each subsequent 512-cycle period:
  - led[0] high for 128 cycles, starting 1 cycle after frame_start;
  - led[7] high for 510 cycles;
  - all other leds 0.
- Glitch-free update: write ch0=200 mid-period → current period keeps 64 (128 cycles high); next period shows 400 cycles high.
- Commit collision: write ch1=10 on exactly the commit cycle → the period starting there shows the old ch1 value; ch1=10 (20 high cycles) appears one period later.
- Boundary/invalid: duty_ch out of range (CHANNELS=6, write ch=7) → no output change. ch2=0 → constant 0. Assert rst_n low mid-period → all outputs 0 asynchronously, before the next clk edge.
- LED_PWM_GAMMA_EN defined: write ch0=128, ch1=1 → ch0 high 128 cycles (64 ticks); ch1 constant 0.
